// File: rtl/sc_leveltimer.sv
// ============================================================================
// Module      : sc_leveltimer
// Description : Programmable period timer with a one-cycle expiry tick and a
//               saturating level count for the game state machine.
//               Optional macro SC_LEVELTIMER_PRESCALER_EN adds a
//               divide-by-PRESCALE_DIV prescaler on the count unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_leveltimer #(
    parameter int PERIOD_WIDTH = 32,
    parameter int LEVEL_WIDTH  = 8,
    parameter int LEVEL_MAX    = 59,
    parameter int PRESCALE_DIV = 50
) (
    input  logic                    SC_LEVELTIMER_CLOCK_50,
    input  logic                    SC_LEVELTIMER_RESET_InLow,
    input  logic                    SC_LEVELTIMER_START_InLow,
    input  logic [PERIOD_WIDTH-1:0] SC_LEVELTIMER_PERIOD_InBUS,
    input  logic                    SC_LEVELTIMER_LOAD_InHigh,
    input  logic                    SC_LEVELTIMER_PAUSE_InHigh,
    output logic                    SC_LEVELTIMER_TICK_OutHigh,
    output logic [LEVEL_WIDTH-1:0]  SC_LEVELTIMER_LEVEL_OutBUS,
    output logic                    SC_LEVELTIMER_LEVELMAX_OutHigh,
    output logic                    SC_LEVELTIMER_RUNNING_OutHigh
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] c_period_one = PERIOD_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0]  c_level_max  = LEVEL_WIDTH'(LEVEL_MAX);

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEVEL_WIDTH-1:0]  level_q, level_d;
    logic                    tick_q, tick_d;
    logic                    levelmax_q, levelmax_d;
    logic                    running_q, running_d;
    logic                    start_prev_q;

    logic                    w_start;
    logic [PERIOD_WIDTH-1:0] w_period_in;
    logic [LEVEL_WIDTH-1:0]  w_level_inc;
    logic                    w_unit_en;

`ifdef SC_LEVELTIMER_PRESCALER_EN
    localparam int PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0] c_ps_last = PS_W'(PRESCALE_DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    assign w_unit_en = (ps_q == c_ps_last);
`else
    assign w_unit_en = 1'b1;
`endif

    assign w_start     = start_prev_q & ~SC_LEVELTIMER_START_InLow;
    // A zero period would never expire, so it is promoted to one count unit.
    assign w_period_in = (SC_LEVELTIMER_PERIOD_InBUS == '0) ? c_period_one
                                                            : SC_LEVELTIMER_PERIOD_InBUS;
    assign w_level_inc = level_q + LEVEL_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        levelmax_d = levelmax_q;
        tick_d     = 1'b0;
`ifdef SC_LEVELTIMER_PRESCALER_EN
        ps_d       = ps_q;
`endif
        if (w_start) begin
            period_d   = w_period_in;
            cnt_d      = w_period_in - c_period_one;
            level_d    = '0;
            levelmax_d = 1'b0;
            state_d    = S_RUN;
`ifdef SC_LEVELTIMER_PRESCALER_EN
            ps_d       = '0;
`endif
        end else begin
            case (state_q)
                S_RUN, S_PAUSE: begin
                    if (SC_LEVELTIMER_LOAD_InHigh) begin
                        period_d = w_period_in;
                        cnt_d    = w_period_in - c_period_one;
`ifdef SC_LEVELTIMER_PRESCALER_EN
                        ps_d     = '0;
`endif
                    end else if (SC_LEVELTIMER_PAUSE_InHigh) begin
                        state_d = S_PAUSE;
                    end else begin
                        // Leaving PAUSE counts on the same edge, so the
                        // freeze lasts exactly as long as PAUSE is high.
                        state_d = S_RUN;
`ifdef SC_LEVELTIMER_PRESCALER_EN
                        ps_d    = w_unit_en ? '0 : ps_q + PS_W'(1);
`endif
                        if (w_unit_en) begin
                            if (cnt_q == '0) begin
                                tick_d  = 1'b1;
                                cnt_d   = period_q - c_period_one;
                                level_d = w_level_inc;
                                if (w_level_inc == c_level_max) begin
                                    state_d    = S_DONE;
                                    levelmax_d = 1'b1;
                                end
                            end else begin
                                cnt_d = cnt_q - c_period_one;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge SC_LEVELTIMER_CLOCK_50 or negedge SC_LEVELTIMER_RESET_InLow) begin
        if (!SC_LEVELTIMER_RESET_InLow) begin
            state_q      <= S_IDLE;
            period_q     <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
            tick_q       <= 1'b0;
            levelmax_q   <= 1'b0;
            running_q    <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            tick_q       <= tick_d;
            levelmax_q   <= levelmax_d;
            running_q    <= running_d;
            start_prev_q <= SC_LEVELTIMER_START_InLow;
        end
    end

`ifdef SC_LEVELTIMER_PRESCALER_EN
    always_ff @(posedge SC_LEVELTIMER_CLOCK_50 or negedge SC_LEVELTIMER_RESET_InLow) begin
        if (!SC_LEVELTIMER_RESET_InLow) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`endif

    assign SC_LEVELTIMER_TICK_OutHigh     = tick_q;
    assign SC_LEVELTIMER_LEVEL_OutBUS     = level_q;
    assign SC_LEVELTIMER_LEVELMAX_OutHigh = levelmax_q;
    assign SC_LEVELTIMER_RUNNING_OutHigh  = running_q;

endmodule

`default_nettype wire
